// File: rtl/tube_pkg.sv
// Shared constants and FSM encoding for the seven-segment tube formatter.
package tube_pkg;

  localparam logic        MODE_HEX   = 1'b0;
  localparam logic        MODE_DEC   = 1'b1;
  localparam int          BCD_W      = 40;
  localparam int          CONV_ITERS = 32;
  localparam logic [31:0] SAT_VALUE  = 32'h9999_9999;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: every BCD digit of 5 or more gets +3 before the shift.
module bcd_add3
  import tube_pkg::*;
#(
  parameter int NDIG = BCD_W / 4
) (
  input  logic [4*NDIG-1:0] bcd_in,
  output logic [4*NDIG-1:0] bcd_out
);

  always_comb begin
    bcd_out = bcd_in;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_in[4*i +: 4] >= 4'd5) begin
        bcd_out[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
      end
    end
  end

endmodule

// File: rtl/tube_data_fmt.sv
// Display word formatter: hex passthrough or sequential binary-to-BCD, with the
// shown value only ever replaced by a hex write or a completed conversion.
module tube_data_fmt
  import tube_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [31:0]           wr_data,
  input  logic                  wr_mode,
  output logic [4*DIGITS-1:0]   show_data,
  output logic                  busy,
  output logic                  ovf,
  output logic                  upd
);

  localparam int          SHOW_W    = 4 * DIGITS;
  localparam logic [4:0]  LAST_ITER = 5'(CONV_ITERS - 1);

  state_t             state, state_nx;
  logic [4:0]         cnt;
  logic [31:0]        bin_sr;
  logic [BCD_W-1:0]   bcd_sr;
  logic [BCD_W-1:0]   bcd_adj;
  logic               hex_wr, load, shift_en, commit;

  // Digits beyond the displayed ones mean the value does not fit on the tube.
  function automatic logic dec_ovf(input logic [BCD_W-1:0] bcd);
    return bcd[BCD_W-1:SHOW_W] != '0;
  endfunction

  function automatic logic [SHOW_W-1:0] sat_dec(input logic [BCD_W-1:0] bcd);
    if (SAT_EN && dec_ovf(bcd)) begin
      return SAT_VALUE;
    end
    return bcd[SHOW_W-1:0];
  endfunction

  bcd_add3 #(.NDIG(BCD_W / 4)) u_add3 (
    .bcd_in  (bcd_sr),
    .bcd_out (bcd_adj)
  );

  // A new write of either kind overrides whatever the FSM was doing.
  always_comb begin
    state_nx = state;
    hex_wr   = 1'b0;
    load     = 1'b0;
    shift_en = 1'b0;
    commit   = 1'b0;
    if (wr_en && wr_mode == MODE_HEX) begin
      hex_wr   = 1'b1;
      state_nx = IDLE;
    end else if (wr_en) begin
      load     = 1'b1;
      state_nx = SHIFT;
    end else begin
      case (state)
        SHIFT: begin
          shift_en = 1'b1;
          if (cnt == LAST_ITER) state_nx = COMMIT;
        end
        COMMIT: begin
          commit   = 1'b1;
          state_nx = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      bin_sr    <= '0;
      bcd_sr    <= '0;
      show_data <= '0;
      ovf       <= 1'b0;
      upd       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      upd  <= hex_wr | commit;
      busy <= (state_nx != IDLE);
      if (hex_wr) begin
        show_data <= wr_data;
        ovf       <= 1'b0;
      end
      if (load) begin
        bin_sr <= wr_data;
        bcd_sr <= '0;
        cnt    <= '0;
      end
      if (shift_en) begin
        {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
        cnt              <= cnt + 5'd1;
      end
      if (commit) begin
        show_data <= sat_dec(bcd_sr);
        ovf       <= dec_ovf(bcd_sr);
      end
    end
  end

endmodule
